// File: rtl/pipeline_regfile.sv
// 32x64 register file with registered dual read ports for the EX stage.
// Define REGFILE_BYPASS_EN for write-first forwarding into the read registers.
module pipeline_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [4:0]  rs1_ID,
    input  logic [4:0]  rs2_ID,
    input  logic [4:0]  rd_WB,
    input  logic [63:0] write_data_WB,
    input  logic        reg_write_WB,
    input  logic [4:0]  dbg_addr,
    output logic [63:0] rs1_data_EX,
    output logic [63:0] rs2_data_EX,
    output logic [63:0] dbg_data
);

    logic [63:0] regs [32];
    logic        wr_en;
    logic [63:0] rd1;
    logic [63:0] rd2;

    assign wr_en = reg_write_WB && (rd_WB != 5'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 64'd0;
            end
        end else if (wr_en) begin
            regs[rd_WB] <= write_data_WB;
        end
    end

    // x0 is decoded to zero so it never depends on array contents
    always_comb begin
        rd1 = (rs1_ID == 5'd0) ? 64'd0 : regs[rs1_ID];
        rd2 = (rs2_ID == 5'd0) ? 64'd0 : regs[rs2_ID];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (rd_WB == rs1_ID)) begin
            rd1 = write_data_WB;
        end
        if (wr_en && (rd_WB == rs2_ID)) begin
            rd2 = write_data_WB;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rs1_data_EX <= 64'd0;
            rs2_data_EX <= 64'd0;
        end else if (flush) begin
            rs1_data_EX <= 64'd0;
            rs2_data_EX <= 64'd0;
        end else if (!stall) begin
            rs1_data_EX <= rd1;
            rs2_data_EX <= rd2;
        end
    end

    assign dbg_data = (dbg_addr == 5'd0) ? 64'd0 : regs[dbg_addr];

endmodule

// File: doc/pipeline_regfile.md
PIPELINE_REGFILE -- requirements
Module: pipeline_regfile

Interface
REQ-001 The block SHALL use one clock and a synchronous active-high reset. The ports are `clk` and `reset`.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high; sampled on the rising edge of clk.
REQ-004 stall  input  1  when high, the read-result registers hold their value.
REQ-005 flush  input  1  when high, the read-result registers load zero (bubble).
REQ-006 rs1_ID  input  5  source register 1 address from the decode stage.
REQ-007 rs2_ID  input  5  source register 2 address from the decode stage.
REQ-008 rd_WB  input  5  write-back destination address.
REQ-009 write_data_WB  input  64  write-back data.
REQ-010 reg_write_WB  input  1  write-back enable.
REQ-011 dbg_addr  input  5  debug read address.
REQ-012 rs1_data_EX  output  64  registered rs1 operand for the execute stage.
REQ-013 rs2_data_EX  output  64  registered rs2 operand for the execute stage.
REQ-014 dbg_data  output  64  combinational debug read of the array.

Function
REQ-015 The storage SHALL be 32 entries x 64 bits, with a single write port and two synchronous read ports plus one debug port.
REQ-016 Write rule: on a rising edge with reg_write_WB=1 and rd_WB!=0, entry[rd_WB] SHALL be updated with write_data_WB.
REQ-017 Writes SHALL NOT be gated by stall or flush.
REQ-018 Entry 0 SHALL always read 0. Writes to x0 SHALL be discarded without changing any state.
REQ-019 Read latency SHALL be one cycle: rs1_ID/rs2_ID sampled at edge N appear on rs1_data_EX/rs2_data_EX after edge N.
REQ-020 Read-register update priority per edge SHALL be: reset, then flush (load 0), then stall (hold), else load the read value.
REQ-021 flush and stall asserted together: flush SHALL win.
REQ-022 Both read ports SHALL be independent. rs1_ID==rs2_ID SHALL return identical data on both outputs.
REQ-023 dbg_data SHALL be the pure combinational value of entry[dbg_addr] (0 for address 0). It SHALL never be bypassed.
REQ-024 All arithmetic SHALL be none. Data SHALL pass unchanged at full 64-bit width, with no sign or zero extension.

Reset
REQ-025 reset=1 at a rising edge SHALL clear all 32 entries, rs1_data_EX and rs2_data_EX to 0.
REQ-026 reset SHALL take priority over a simultaneous write, stall or flush. A write coincident with reset SHALL be lost.
REQ-027 After reset deasserts, the first edge SHALL behave as normal operation. No warm-up cycle SHALL exist.

Configuration
REQ-028 Macro REGFILE_BYPASS_EN SHALL select write-to-read forwarding inside the block.
REQ-029 With REGFILE_BYPASS_EN defined: if at an edge reg_write_WB=1, rd_WB!=0 and rd_WB==rsX_ID, rsX_data_EX SHALL load write_data_WB (write-first).
REQ-030 Without REGFILE_BYPASS_EN: rsX_data_EX SHALL load the pre-write array value (read-first). The external forwarding unit SHALL cover the WB-to-ID hazard.
REQ-031 The bypass, when present, SHALL obey the stall/flush priority of REQ-020.

Verification
REQ-032 Reset then rs1_ID=5, rs2_ID=31 -> both outputs 0 one cycle later; dbg_addr=5 -> dbg_data=0.
REQ-033 Write x3=0xDEAD_BEEF_0123_4567, next cycle rs1_ID=3 -> rs1_data_EX=0xDEAD_BEEF_0123_4567 after one edge; dbg_addr=3 matches after the write edge.
REQ-034 reg_write_WB=1, rd_WB=0, data=0xFFFF_FFFF_FFFF_FFFF, then read x0 on both ports -> 0; dbg_data for address 0 -> 0.
REQ-035 Same-edge write x7=0x1234 with rs1_ID=7, prior x7=0x55 -> rs1_data_EX=0x1234 with REGFILE_BYPASS_EN defined, 0x55 without it; the following read -> 0x1234 in both builds.
REQ-036 Load rs2_data_EX=0xAA, assert stall for 3 cycles while rs2_ID changes and x9 is written -> output stays 0xAA; the x9 write is visible after stall drops.
REQ-037 stall=1 and flush=1 together -> outputs 0. reset=1 coincident with write x4=0x77 -> x4 reads 0 afterwards.
